// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcodes, funct fields, FSM states and immediate decoders for the multicycle core
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 32x32 register file, two combinational reads, one clocked write, x0 fixed at zero
module riscv_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];

endmodule

// File: rtl/riscv_multicycle_core.sv
// rtl/riscv_multicycle_core.sv - multicycle RV32 integer core with mul, handshaked memories and trap/halt states
module riscv_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16,
    parameter bit          MUL_EN   = 1'b1,
    parameter logic [31:0] EOF_WORD = 32'h1111_1111
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] clock_count,
    output logic [CNT_W-1:0] instr_count
);
    import riscv_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state, state_nx;
    logic [31:0] pc, pc_cur, ir, op_a, op_b, alu_out, mdr;
    logic [31:0] rf_rdata1, rf_rdata2, exec_res, mem_addr, br_target, jal_target;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        legal, br_taken, retire;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    riscv_regfile u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (ir[19:15]),
        .raddr2 (ir[24:20]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (state == S_WB),
        .waddr  (ir[11:7]),
        .wdata  ((opcode == OP_LOAD) ? mdr : alu_out)
    );

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:              legal = (funct3 == F3_ADD) &&
                                       (funct7 == F7_BASE || funct7 == F7_SUB || (MUL_EN && funct7 == F7_MUL));
            OP_IMM:            legal = (funct3 == F3_ADD) || (funct3 == F3_SLL && funct7 == F7_BASE);
            OP_LOAD, OP_STORE: legal = (funct3 == F3_LW);
            OP_BRANCH:         legal = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
            OP_LUI, OP_JAL:    legal = 1'b1;
            default:           legal = 1'b0;
        endcase
    end

    // Operands stay latched through EXEC and MEM, so the data address is stable without its own register.
    always_comb begin
        exec_res   = 32'h0;
        mem_addr   = op_a + ((opcode == OP_STORE) ? imm_s(ir) : imm_i(ir));
        br_target  = pc_cur + imm_b(ir);
        jal_target = pc_cur + imm_j(ir);
        case (opcode)
            OP_R: begin
                if (funct7 == F7_SUB)      exec_res = op_a - op_b;
                else if (funct7 == F7_MUL) exec_res = op_a * op_b;
                else                       exec_res = op_a + op_b;
            end
            OP_IMM:  exec_res = (funct3 == F3_SLL) ? (op_a << ir[24:20]) : (op_a + imm_i(ir));
            OP_LUI:  exec_res = imm_u(ir);
            OP_JAL:  exec_res = pc_cur + 32'd4;
            default: exec_res = 32'h0;
        endcase
        case (funct3)
            F3_BEQ:  br_taken = (op_a == op_b);
            F3_BNE:  br_taken = (op_a != op_b);
            F3_BLT:  br_taken = ($signed(op_a) < $signed(op_b));
            F3_BGE:  br_taken = ($signed(op_a) >= $signed(op_b));
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        imem_req   = 1'b0;
        imem_addr  = 32'h0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        case (state)
            S_FETCH: begin
                // Gated by rst_n so a pending fetch is withdrawn the moment reset asserts.
                imem_req  = rst_n;
                imem_addr = rst_n ? pc : 32'h0;
                if (imem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (ir == EOF_WORD)  state_nx = S_HALT;
                else if (!legal)     state_nx = S_TRAP;
                else                 state_nx = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nx = (mem_addr[1:0] != 2'b00) ? S_TRAP : S_MEM;
                    OP_BRANCH:         state_nx = (br_taken && br_target[1]) ? S_TRAP : S_FETCH;
                    OP_JAL:            state_nx = jal_target[1] ? S_TRAP : S_WB;
                    default:           state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (opcode == OP_STORE);
                dmem_addr  = mem_addr;
                dmem_wdata = (opcode == OP_STORE) ? op_b : 32'h0;
                if (dmem_ready) state_nx = (opcode == OP_STORE) ? S_FETCH : S_WB;
            end
            S_WB:    state_nx = S_FETCH;
            default: state_nx = state;
        endcase
    end

    assign done    = (state == S_HALT);
    assign illegal = (state == S_TRAP);
    assign retire  = (state inside {S_EXEC, S_MEM, S_WB}) && (state_nx == S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pc_cur      <= '0;
            ir          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            alu_out     <= '0;
            mdr         <= '0;
            clock_count <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            if (state != S_HALT && state != S_TRAP && clock_count != CNT_MAX)
                clock_count <= clock_count + CNT_ONE;
            if (retire && instr_count != CNT_MAX)
                instr_count <= instr_count + CNT_ONE;
            case (state)
                S_FETCH: if (imem_ready) begin
                    ir     <= imem_rdata;
                    pc_cur <= pc;
                    pc     <= pc + 32'd4;
                end
                S_DECODE: begin
                    op_a <= rf_rdata1;
                    op_b <= rf_rdata2;
                end
                S_EXEC: begin
                    alu_out <= exec_res;
                    // A misaligned target traps with pc left at pc_cur+4.
                    if (opcode == OP_BRANCH && br_taken && !br_target[1]) pc <= br_target;
                    if (opcode == OP_JAL && !jal_target[1])               pc <= jal_target;
                end
                S_MEM: if (dmem_ready) mdr <= dmem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// tb/tb_riscv_multicycle_core.sv - directed and random programs checked against a program-level model
module tb_riscv_multicycle_core;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          CNT_W    = 6;
    localparam int          CNT_MAX  = 63;
    localparam logic [31:0] EOF_WORD = 32'h1111_1111;

    typedef enum {K_ADD, K_SUB, K_MUL, K_ADDI, K_SLLI, K_LW, K_SW, K_LUI,
                  K_BEQ, K_BNE, K_BLT, K_BGE, K_JAL, K_ILL, K_EOF} kind_t;
    typedef struct {kind_t k; int rd; int rs1; int rs2; int imm;} ins_t;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             imem_req, imem_ready = 1'b0;
    logic [31:0]      imem_addr, imem_rdata = 32'h0;
    logic             dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata = 32'h0;
    logic             done, illegal;
    logic [CNT_W-1:0] clock_count, instr_count;

    riscv_multicycle_core #(.RESET_PC(RESET_PC), .CNT_W(CNT_W), .MUL_EN(1'b1), .EOF_WORD(EOF_WORD)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .done(done), .illegal(illegal), .clock_count(clock_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [256];
    logic [31:0] dmem [64];
    ins_t        prog [128];
    int          plen;
    int          n_chk = 0, n_pass = 0;
    int          iw_lo = 0, iw_hi = 0, dw_lo = 0, dw_hi = 0;
    int          iw_cnt = 0, iw_cur = 0, dw_cnt = 0, dw_cur = 0;
    int          n_wait = 0, n_store = 0, n_dacc = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];
    int          m_cyc, m_ins, m_stores, m_memops;
    bit          m_halt, m_trap;
    logic [31:0] m_tpc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory responders: each access waits a chosen number of cycles, then grants ready.
    always @(negedge clk) begin
        if (imem_req) begin
            if (iw_cnt < iw_cur) begin
                imem_ready = 1'b0; iw_cnt++; n_wait++;
            end else begin
                imem_ready = 1'b1; imem_rdata = imem[imem_addr[9:2]];
            end
        end else begin
            imem_ready = 1'b0; iw_cnt = 0; iw_cur = $urandom_range(iw_lo, iw_hi);
        end
        if (dmem_req) begin
            if (dw_cnt < dw_cur) begin
                dmem_ready = 1'b0; dw_cnt++; n_wait++;
            end else begin
                dmem_ready = 1'b1; dmem_rdata = dmem[dmem_addr[7:2]]; n_dacc++;
                if (dmem_we) begin dmem[dmem_addr[7:2]] = dmem_wdata; n_store++; end
            end
        end else begin
            dmem_ready = 1'b0; dw_cnt = 0; dw_cur = $urandom_range(dw_lo, dw_hi);
        end
    end

    function automatic void emit(kind_t k, int rd, int rs1, int rs2, int imm);
        prog[plen] = '{k, rd, rs1, rs2, imm};
        plen++;
    endfunction

    function automatic logic [31:0] encode(ins_t in);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [31:0] raw;
        logic [2:0]  f3;
        rd = in.rd[4:0]; rs1 = in.rs1[4:0]; rs2 = in.rs2[4:0];
        raw = in.imm; i12 = raw[11:0]; b13 = raw[12:0]; j21 = raw[20:0];
        f3 = (in.k == K_BNE) ? 3'b001 : (in.k == K_BLT) ? 3'b100 : (in.k == K_BGE) ? 3'b101 : 3'b000;
        case (in.k)
            K_ADD:  return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:  return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_MUL:  return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_ADDI: return {i12, rs1, 3'b000, rd, 7'b0010011};
            K_SLLI: return {7'b0000000, raw[4:0], rs1, 3'b001, rd, 7'b0010011};
            K_LW:   return {i12, rs1, 3'b010, rd, 7'b0000011};
            K_SW:   return {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'b0100011};
            K_LUI:  return {raw[19:0], rd, 7'b0110111};
            K_BEQ, K_BNE, K_BLT, K_BGE:
                    return {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'b1100011};
            K_JAL:  return {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'b1101111};
            K_ILL:  return raw;
            default: return EOF_WORD;
        endcase
    endfunction

    // Instruction-level interpreter: per-class latencies (branch 3, lw 5, others 4, EOF fetch+decode 2).
    task automatic model_run();
        logic [31:0] pc, a, b, addr, tgt, res, nxt;
        ins_t in;
        bit wr, take, trap;
        int idx, lat;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int i = 0; i < 64; i++) m_dmem[i] = dmem[i];
        m_cyc = 0; m_ins = 0; m_stores = 0; m_memops = 0; m_halt = 0; m_trap = 0; m_tpc = '0;
        pc = RESET_PC;
        for (int step = 0; step < 4000; step++) begin
            idx = int'((pc - RESET_PC) >> 2);
            if (idx >= plen) in = '{K_EOF, 0, 0, 0, 0};
            else in = prog[idx];
            if (in.k == K_EOF) begin m_cyc += 2; m_halt = 1; break; end
            if (in.k == K_ILL) begin m_cyc += 2; m_trap = 1; m_tpc = pc; break; end
            a = m_regs[in.rs1]; b = m_regs[in.rs2];
            nxt = pc + 4; lat = 4; wr = 1; res = '0; trap = 0; take = 0;
            case (in.k)
                K_ADD:  res = a + b;
                K_SUB:  res = a - b;
                K_MUL:  res = a * b;
                K_ADDI: res = a + 32'(in.imm);
                K_SLLI: res = a << in.imm;
                K_LUI:  res = 32'(in.imm) << 12;
                K_LW: begin
                    addr = a + 32'(in.imm);
                    if (addr % 4 != 0) trap = 1;
                    else begin res = m_dmem[addr[7:2]]; lat = 5; m_memops++; end
                end
                K_SW: begin
                    wr = 0; addr = a + 32'(in.imm);
                    if (addr % 4 != 0) trap = 1;
                    else begin m_dmem[addr[7:2]] = b; m_memops++; m_stores++; end
                end
                K_JAL: begin
                    tgt = pc + 32'(in.imm);
                    if (tgt[1]) trap = 1;
                    else begin res = pc + 4; nxt = tgt; end
                end
                default: begin
                    wr = 0; lat = 3;
                    case (in.k)
                        K_BEQ:   take = (a == b);
                        K_BNE:   take = (a != b);
                        K_BLT:   take = ($signed(a) < $signed(b));
                        default: take = ($signed(a) >= $signed(b));
                    endcase
                    tgt = pc + 32'(in.imm);
                    if (take && tgt[1]) trap = 1;
                    else if (take) nxt = tgt;
                end
            endcase
            if (trap) begin m_cyc += 3; m_trap = 1; m_tpc = pc; break; end
            if (wr && in.rd != 0) m_regs[in.rd] = res;
            m_cyc += lat; m_ins++; pc = nxt;
        end
    endtask

    task automatic run_prog(input string name, input int ilo, input int ihi, input int dlo, input int dhi);
        int cyc;
        rst_n = 1'b0;
        iw_lo = ilo; iw_hi = ihi; dw_lo = dlo; dw_hi = dhi;
        for (int i = 0; i < 256; i++) imem[i] = EOF_WORD;
        for (int i = 0; i < plen; i++) imem[64 + i] = encode(prog[i]);
        for (int i = 0; i < 64; i++) dmem[i] = $urandom;
        model_run();
        @(posedge clk); #2;
        n_wait = 0; n_store = 0; n_dacc = 0;
        rst_n = 1'b1;
        cyc = 0;
        while (!(done || illegal) && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check({name, ":timeout"}, 32'(cyc < 3000), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check({name, ":done"}, 32'(done), 32'(m_halt));
        check({name, ":illegal"}, 32'(illegal), 32'(m_trap));
        check({name, ":instr_count"}, 32'(instr_count), 32'((m_ins > CNT_MAX) ? CNT_MAX : m_ins));
        check({name, ":clock_count"}, 32'(clock_count),
              32'((m_cyc + n_wait > CNT_MAX) ? CNT_MAX : m_cyc + n_wait));
        check({name, ":stores"}, 32'(n_store), 32'(m_stores));
        check({name, ":dmem_accesses"}, 32'(n_dacc), 32'(m_memops));
        if (m_trap) check({name, ":pc_cur"}, u_dut.pc_cur, m_tpc);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s:x%0d", name, i), u_dut.u_rf.regs[i], m_regs[i]);
        for (int i = 0; i < 64; i++)
            if (dmem[i] !== m_dmem[i]) check($sformatf("%s:dmem[%0d]", name, i), dmem[i], m_dmem[i]);
    endtask

    task automatic reset_test();
        plen = 0;
        emit(K_ADDI, 1, 0, 0, 1);
        rst_n = 1'b0;
        iw_lo = 20; iw_hi = 20; dw_lo = 0; dw_hi = 0;
        for (int i = 0; i < 256; i++) imem[i] = EOF_WORD;
        imem[64] = encode(prog[0]);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:req_waiting", 32'(imem_req), 32'd1);
        check("rst:addr_waiting", imem_addr, RESET_PC);
        check("rst:clock_while_waiting", 32'(clock_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst:req_dropped", 32'(imem_req), 32'd0);
        check("rst:addr_zero", imem_addr, 32'h0);
        check("rst:clock_zero", 32'(clock_count), 32'd0);
        check("rst:instr_zero", 32'(instr_count), 32'd0);
        iw_lo = 0; iw_hi = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("rst:restart_addr", imem_addr, RESET_PC);
        repeat (4) @(posedge clk);
        #1;
        check("rst:first_retire", 32'(instr_count), 32'd1);
        check("rst:first_clock", 32'(clock_count), 32'd4);
        check("rst:x1", u_dut.u_rf.regs[1], 32'd1);
    endtask

    task automatic gen_random(input int n);
        plen = 0;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 12))
                0:  emit(K_ADD,  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
                1:  emit(K_SUB,  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
                2:  emit(K_MUL,  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
                3:  emit(K_ADDI, $urandom_range(0, 7), $urandom_range(0, 7), 0, int'($urandom_range(0, 4095)) - 2048);
                4:  emit(K_SLLI, $urandom_range(0, 7), $urandom_range(0, 7), 0, $urandom_range(0, 31));
                5:  emit(K_LW,   $urandom_range(0, 7), 0, 0, 4 * $urandom_range(0, 63));
                6:  emit(K_SW,   0, 0, $urandom_range(0, 7), 4 * $urandom_range(0, 63));
                7:  emit(K_LUI,  $urandom_range(0, 7), 0, 0, $urandom_range(0, 20'hFFFFF));
                8:  emit(K_BEQ,  0, $urandom_range(0, 7), $urandom_range(0, 7), 4 * $urandom_range(1, 3));
                9:  emit(K_BNE,  0, $urandom_range(0, 7), $urandom_range(0, 7), 4 * $urandom_range(1, 3));
                10: emit(K_BLT,  0, $urandom_range(0, 7), $urandom_range(0, 7), 4 * $urandom_range(1, 3));
                11: emit(K_BGE,  0, $urandom_range(0, 7), $urandom_range(0, 7), 4 * $urandom_range(1, 3));
                default: emit(K_JAL, $urandom_range(0, 7), 0, 0, 4 * $urandom_range(1, 2));
            endcase
        end
        for (int i = 0; i < 4; i++) emit(K_EOF, 0, 0, 0, 0);
    endtask

    initial begin
        plen = 0;
        emit(K_ADDI, 1, 0, 0, 5); emit(K_ADDI, 2, 0, 0, -3); emit(K_ADD, 3, 1, 2, 0);
        emit(K_SUB, 4, 1, 2, 0);  emit(K_MUL, 5, 1, 2, 0);  emit(K_EOF, 0, 0, 0, 0);
        run_prog("arith", 0, 0, 0, 0);

        plen = 0;
        emit(K_ADDI, 1, 0, 0, 5); emit(K_SW, 0, 0, 1, 8); emit(K_LW, 6, 0, 0, 8); emit(K_EOF, 0, 0, 0, 0);
        run_prog("ldst_wait", 0, 0, 2, 2);

        plen = 0;
        emit(K_ADDI, 1, 0, 0, 0); emit(K_ADDI, 2, 0, 0, 3); emit(K_ADDI, 1, 1, 0, 1);
        emit(K_BLT, 0, 1, 2, -4); emit(K_EOF, 0, 0, 0, 0);
        run_prog("loop", 0, 0, 0, 0);

        plen = 0;
        emit(K_ADDI, 0, 0, 0, 7); emit(K_JAL, 7, 0, 0, 8); emit(K_ADDI, 8, 0, 0, 99);
        emit(K_ADDI, 9, 0, 0, 1); emit(K_EOF, 0, 0, 0, 0);
        run_prog("x0_jal", 1, 2, 0, 0);

        plen = 0;
        emit(K_LW, 1, 0, 0, 2); emit(K_EOF, 0, 0, 0, 0);
        run_prog("trap_misaligned", 0, 0, 0, 0);

        plen = 0;
        emit(K_ADDI, 1, 0, 0, 4); emit(K_ILL, 0, 0, 0, 32'h0000_0073); emit(K_EOF, 0, 0, 0, 0);
        run_prog("trap_opcode", 0, 0, 0, 0);

        plen = 0;
        emit(K_ADDI, 1, 0, 0, 1); emit(K_BNE, 0, 1, 0, 6); emit(K_EOF, 0, 0, 0, 0);
        run_prog("trap_branch_target", 0, 0, 0, 0);

        plen = 0;
        for (int i = 0; i < 70; i++) emit(K_ADDI, 1, 1, 0, 1);
        emit(K_EOF, 0, 0, 0, 0);
        run_prog("saturate", 0, 0, 0, 0);

        reset_test();

        for (int r = 0; r < 6; r++) begin
            gen_random(25);
            run_prog($sformatf("rand%0d", r), 0, 2, 0, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
